// File: rtl/alu_pipe.sv
// Registered ALU with iterative shift-add MUL and condition flags; 1 cycle latency (MUL: WIDTH cycles).
// Output register is valid/ready; in_ready drops while a result is stalled or a MUL is iterating.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  flags_t           flags_q, alu_flags;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_next;
  logic [SHW-1:0]   cnt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] b_op;
  logic [SHW-1:0]   sh;
  logic             is_sub, is_mul, accept, mul_last;

  assign is_sub   = (opcode[4:1] == 4'b0001);
  assign is_mul   = (opcode == 5'b01010);
  assign accept   = in_valid && in_ready;
  assign mul_last = (state_q == S_MUL) && (cnt == CNT_LAST);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign sh       = b_in[SHW-1:0];

  // SUB reuses the adder as A + ~B + 1 so carry-out doubles as not-borrow.
  assign b_op    = is_sub ? ~b_in : b_in;
  assign sum_ext = {1'b0, a_in} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    alu_res     = sum_ext[WIDTH-1:0];
    alu_flags.c = sum_ext[WIDTH];
    alu_flags.v = (a_in[WIDTH-1] == b_op[WIDTH-1]) && (sum_ext[WIDTH-1] != a_in[WIDTH-1]);
    casez (opcode)
      5'b0000?: ;
      5'b0001?: ;
      5'b00100: begin alu_res = a_in >> sh;             alu_flags.c = 1'b0; alu_flags.v = 1'b0; end
      5'b00101: begin alu_res = $signed(a_in) >>> sh;   alu_flags.c = 1'b0; alu_flags.v = 1'b0; end
      5'b00110: begin alu_res = a_in << sh;             alu_flags.c = 1'b0; alu_flags.v = 1'b0; end
      5'b00111: begin alu_res = a_in & b_in;            alu_flags.c = 1'b0; alu_flags.v = 1'b0; end
      5'b01000: begin alu_res = a_in | b_in;            alu_flags.c = 1'b0; alu_flags.v = 1'b0; end
      5'b01001: begin alu_res = ~a_in;                  alu_flags.c = 1'b0; alu_flags.v = 1'b0; end
      default: ;
    endcase
    alu_flags.z = ~|alu_res;
    alu_flags.n = alu_res[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_last)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
  end

  // out_valid is always clear while iterating: a MUL start either found it empty or consumed it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc       <= '0;
        mcand     <= a_in;
        mplier    <= b_in;
        cnt       <= '0;
        out_valid <= 1'b0;
      end else begin
        result    <= alu_res;
        flags_q   <= alu_flags;
        out_valid <= 1'b1;
      end
    end else if (state_q == S_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        result    <= acc_next;
        flags_q   <= '{z: ~|acc_next, n: acc_next[WIDTH-1], c: 1'b0, v: 1'b0};
        out_valid <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: scoreboard of expected results, checked with immediate assertions.
module tb_alu_pipe;

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00010, OP_SUB1 = 5'b00011,
                         OP_LSR = 5'b00100, OP_ASR = 5'b00101, OP_SL  = 5'b00110,
                         OP_AND = 5'b00111, OP_OR  = 5'b01000, OP_MUL = 5'b01010;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  opcode;
  logic [31:0] a_in, b_in, result;
  logic        flag_z, flag_n, flag_c, flag_v;

  logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16;
  logic [4:0]  opcode_16;
  logic [15:0] a_in_16, b_in_16, result_16;
  logic        flag_z_16, flag_n_16, flag_c_16, flag_v_16;

  alu_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16), .opcode(opcode_16),
    .a_in(a_in_16), .b_in(b_in_16), .out_valid(out_valid_16), .out_ready(out_ready_16),
    .result(result_16), .flag_z(flag_z_16), .flag_n(flag_n_16), .flag_c(flag_c_16),
    .flag_v(flag_v_16)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  f;   // {z, n, c, v}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   lat, lo, early, seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] res, input logic z, n, c, v);
    exp_t e;
    e.res = res;
    e.f   = {z, n, c, v};
    sb.push_back(e);
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=output expected=empty-scoreboard-has-entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"}, result, e.res);
      chk({tag, "_flags"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, e.f});
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opcode = op; a_in = a; b_in = b; in_valid = 1'b1;
    #1 chk("issue_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    if (out_valid) compare_front(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; a_in = '0; b_in = '0;
    in_valid_16 = 1'b0; out_ready_16 = 1'b1; opcode_16 = '0; a_in_16 = '0; b_in_16 = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1); push(32'h8000_0000, 0, 1, 0, 1);
    expect_out("add_ovf", lat);
    chk("add_latency", lat, 32'd1);

    issue(OP_SUB, 32'd5, 32'd5);  push(32'h0, 1, 0, 1, 0);          expect_out("sub_eq", lat);
    issue(OP_SUB1, 32'd3, 32'd5); push(32'hFFFF_FFFE, 0, 1, 0, 0);  expect_out("sub_neg", lat);

    issue(OP_ASR, 32'h8000_0000, 32'h21); push(32'hC000_0000, 0, 1, 0, 0); expect_out("asr", lat);
    issue(OP_LSR, 32'h8000_0000, 32'h21); push(32'h4000_0000, 0, 0, 0, 0); expect_out("lsr", lat);
    issue(OP_SL,  32'h8000_0000, 32'h21); push(32'h0, 1, 0, 0, 0);         expect_out("sl", lat);

    // Back-to-back: two ops accepted on consecutive edges; the second uses an unlisted opcode.
    @(negedge clk);
    opcode = OP_ADD; a_in = 32'd1; b_in = 32'd2; in_valid = 1'b1; push(32'd3, 0, 0, 0, 0);
    @(posedge clk);
    #1 opcode = 5'b11111; a_in = 32'd10; b_in = 32'd20; push(32'd30, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_vld1", {31'd0, out_valid}, 32'd1);
    chk("b2b_rdy", {31'd0, in_ready}, 32'd1);
    compare_front("b2b1");
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_vld2", {31'd0, out_valid}, 32'd1);
    compare_front("b2b2_unlisted");

    // MUL with operands scrambled right after the accept edge.
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd3); push(32'hFFFF_FFFD, 0, 1, 0, 0);
    a_in = 32'h1234_5678; b_in = 32'h0; opcode = OP_OR;
    lo = 0; early = 0;
    do begin
      @(negedge clk);
      if (!in_ready) begin
        lo++;
        if (out_valid) early++;
      end
    end while (!in_ready && lo < 100);
    chk("mul_rdy_low_cycles", lo, 32'd32);
    chk("mul_early_vld", early, 32'd0);
    chk("mul_vld", {31'd0, out_valid}, 32'd1);
    if (out_valid) compare_front("mul");

    // Backpressure: AND result stalls while an OR is held pending.
    @(negedge clk); out_ready = 1'b0;
    issue(OP_AND, 32'hF0F0, 32'hFF00); push(32'hF000, 0, 0, 0, 0);
    opcode = OP_OR; a_in = 32'h0F; b_in = 32'hF0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", {31'd0, out_valid}, 32'd1);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", result, 32'hF000);
    end
    compare_front("bp_and");
    out_ready = 1'b1; push(32'hFF, 0, 0, 0, 0);
    #1 chk("bp_rdy_release", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_or_vld", {31'd0, out_valid}, 32'd1);
    compare_front("bp_or");

    // Reset in the middle of a MUL discards it.
    issue(OP_MUL, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdy", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mid_no_out", seen, 32'd0);

    // 16-bit instance: MUL whose product overflows to zero.
    @(negedge clk);
    opcode_16 = OP_MUL; a_in_16 = 16'h0100; b_in_16 = 16'h0100; in_valid_16 = 1'b1;
    #1 chk("m16_issue_rdy", {31'd0, in_ready_16}, 32'd1);
    @(posedge clk);
    #1 in_valid_16 = 1'b0;
    lo = 0;
    do begin
      @(negedge clk);
      if (!in_ready_16) lo++;
    end while (!in_ready_16 && lo < 100);
    chk("m16_rdy_low_cycles", lo, 32'd16);
    chk("m16_vld", {31'd0, out_valid_16}, 32'd1);
    chk("m16_res", {16'd0, result_16}, 32'd0);
    chk("m16_flags", {28'd0, flag_z_16, flag_n_16, flag_c_16, flag_v_16}, 32'h8);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

`alu_pipe` is the registered, handshaked, width-parametrised successor to the CPU's combinational ALU, and sits between the execute-stage operand muxes and writeback. It keeps the existing 5-bit opcode map and adds two things: an iterative shift-add multiply, and registered condition flags. Results leave through a valid/ready output register, so the pipeline can stall the ALU or the ALU can stall the pipeline.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two, 8 or greater.
- `SHW`, default `$clog2(WIDTH)`: number of shift-amount bits taken from B. Derived; do not override.
- `clk` in, 1: sole clock, rising edge.
- `rst_n` in, 1: reset, asynchronous assert, active-low.
- `in_valid` in, 1: operands and opcode are presented.
- `in_ready` out, 1: the block accepts an operation this cycle.
- `opcode` in, 5: operation select.
- `a_in` in, WIDTH: operand A, signed.
- `b_in` in, WIDTH: operand B, signed.
- `out_valid` out, 1: the output register holds a result.
- `out_ready` in, 1: the consumer takes the result this cycle.
- `result` out, WIDTH: operation result.
- `flag_z` out, 1: result == 0.
- `flag_n` out, 1: result[WIDTH-1].
- `flag_c` out, 1: carry / not-borrow.
- `flag_v` out, 1: signed overflow.

## Operation
- Opcode map. Any unlisted opcode is treated as ADD.
  - ADD: 0000x
  - SUB: 0001x
  - LSR: 00100
  - ASR: 00101
  - SL: 00110
  - AND: 00111
  - OR: 01000
  - NOT A: 01001
  - MUL: 01010
- Shift amount is `b_in[SHW-1:0]`; upper bits of B are ignored.
  - LSR fills with zeros.
  - ASR replicates `a_in[WIDTH-1]`.
  - SL fills with zeros.
- ADD: computed as a WIDTH+1-bit sum.
  - C = bit WIDTH of the sum.
  - V = (A sign == B sign) && (result sign != A sign).
- SUB: result = A + ~B + 1.
  - C = 1 when A ≥ B unsigned (no borrow).
  - V = (A sign != B sign) && (result sign != A sign).
- Logic ops, shifts, MUL: C = 0, V = 0.
- Z and N are computed from the final result for every op.
- MUL returns the low WIDTH bits of A×B. This is identical for signed and unsigned operands.
- MUL state machine, states IDLE and MUL:
  - IDLE → MUL when a MUL is accepted. Load acc = 0, mcand = A, mplier = B, cnt = 0.
  - In MUL, each cycle: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt += 1.
  - When cnt reaches WIDTH-1, that cycle's update is written to the output register together with flags, out_valid is set, and the FSM returns to IDLE.
- Non-MUL ops never leave IDLE. Their result and flags are written to the output register on the accept edge.

## Timing
- Reset values: `out_valid` = 0, `result` = 0, all flags 0, FSM = IDLE, internal counters and accumulators = 0.
- `in_ready` = (FSM == IDLE) && (!out_valid || out_ready). It is combinational from state and `out_ready`.
- Accept happens on a rising edge with `in_valid && in_ready`.
- Single-cycle op: `out_valid` = 1 in the cycle after acceptance. Back-to-back throughput is one op per cycle while `out_ready` = 1.
- MUL: `in_ready` = 0 for exactly WIDTH cycles after acceptance. `out_valid` rises WIDTH cycles after the accept edge.
- Output register holds:
  - While `out_valid && !out_ready`, `result` and flags stay stable and `in_ready` = 0.
  - A result is consumed on an edge with `out_valid && out_ready`.
  - A simultaneous consume and new accept reloads the register (single-cycle op), or clears `out_valid` (MUL start).
- Input-side rules:
  - Operands are sampled only on the accept edge. Changes to `a_in`, `b_in`, or `opcode` during a MUL have no effect.
  - `in_valid` with `in_ready` = 0 is ignored; the source must hold it.
- Reset mid-MUL: the FSM returns to IDLE, the partial product is discarded, and no output is produced.

## Test plan
- Reset, then WIDTH=32, `out_ready`=1. ADD 0x7FFFFFFF + 1 → result 0x80000000, N=1, V=1, C=0, Z=0. `out_valid` is high one cycle after accept.
- SUB 5 − 5 → result 0, Z=1, C=1. SUB 3 − 5 → 0xFFFFFFFE, N=1, C=0, V=0.
- Shifts with A=0x80000000 and B=0x21 (amount 1): ASR → 0xC0000000, LSR → 0x40000000, SL → 0.
- MUL 0xFFFFFFFF × 3 → 0xFFFFFFFD. `in_ready` is low for 32 cycles; `out_valid` rises 32 cycles after accept. Operand changes mid-op do not alter the result.
- Backpressure: `out_ready`=0 after an AND 0xF0F0 & 0xFF00 → 0xF000 is held with `in_ready`=0 for 5 cycles. Raising `out_ready` together with a pending OR accepts the OR on that edge, and the OR result appears the next cycle.
- Drive `rst_n` low at MUL cycle 10 for 1 cycle → `out_valid` = 0 immediately and `in_ready` = 1 after release. WIDTH=16: MUL 0x0100 × 0x0100 → 0x0000, Z=1.
